// File: rtl/eth_pkt_fifo.sv
// Store-and-forward RX frame FIFO: speculative write with commit/rollback, FWFT read side.
// Optional ETH_PKT_FIFO_DROP_CNT_EN adds a saturating drop_cnt of lost frames.
module eth_pkt_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              wr_drop,
    output logic              wr_ovf,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   frame_cnt,
    output logic [ADDR_W:0]   level
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

    wr_state_t state, state_n;
    logic [ADDR_W:0] wr_ptr, cm_ptr, rd_ptr;
    logic [DATA_W:0] mem [2**ADDR_W];
    logic [DATA_W:0] ram_q;
    logic            ram_v;
    logic            full, wr_en, commit, rollback, ovf_set;
    logic            avail, out_adv, fetch, pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign avail   = (cm_ptr != rd_ptr);
    assign out_adv = !rd_valid || rd_ready;
    // The RAM read stage and the output register form a two-deep pipeline,
    // so the read stage may refill while the output is stalled.
    assign fetch   = avail && (!ram_v || out_adv);
    assign pop     = rd_valid && rd_ready && rd_last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // wr_drop overrides everything, including a same-cycle wr_last.
    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        ovf_set  = 1'b0;
        if (wr_drop) begin
            rollback = 1'b1;
            state_n  = IDLE;
        end else if (wr_valid) begin
            case (state)
                IDLE, RECV: begin
                    if (full) begin
                        if (wr_last) begin
                            rollback = 1'b1;
                            ovf_set  = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            state_n  = DISCARD;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (wr_last) begin
                            commit  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = RECV;
                        end
                    end
                end
                DISCARD: begin
                    if (wr_last) begin
                        rollback = 1'b1;
                        ovf_set  = 1'b1;
                        state_n  = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, wr_data};
        if (fetch) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            wr_ovf    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (rollback)   wr_ptr <= cm_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + ONE;
            if (commit) cm_ptr <= wr_ptr + ONE;
            wr_ovf <= ovf_set;
            if (commit && !pop)      frame_cnt <= frame_cnt + ONE;
            else if (!commit && pop) frame_cnt <= frame_cnt - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            ram_v    <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (fetch) rd_ptr <= rd_ptr + ONE;
            if (fetch)        ram_v <= 1'b1;
            else if (out_adv) ram_v <= 1'b0;
            if (out_adv) begin
                rd_valid <= ram_v;
                if (ram_v) {rd_last, rd_data} <= ram_q;
            end
        end
    end

`ifdef ETH_PKT_FIFO_DROP_CNT_EN
    logic lost;
    assign lost = ovf_set || (wr_drop && (state != IDLE || wr_valid));

    always_ff @(posedge clk) begin
        if (rst)                               drop_cnt <= '0;
        else if (lost && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Directed bench for eth_pkt_fifo (DATA_W=16, ADDR_W=4): commit, drop, overflow, stalls, reset.
module tb_eth_pkt_fifo;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst, wr_valid, wr_last, wr_drop, rd_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ovf, rd_valid, rd_last;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   frame_cnt, level;
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    eth_pkt_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_drop(wr_drop),
        .wr_ovf(wr_ovf),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
        .frame_cnt(frame_cnt), .level(level)
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic last);
        wr_valid = 1'b1; wr_data = d; wr_last = last;
        cyc();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    logic [DATA_W-1:0] exp_d [5];
    logic              exp_l [5];

    initial begin
        int ovf_n, got;
        logic [DATA_W-1:0] prev;
        logic pv, rr;
        rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_drop = 1'b0;
        wr_data = '0; rd_ready = 1'b0;
        cyc(); cyc();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_wr_ovf", wr_ovf, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        // 1: 4-beat frame, reader always ready
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) beat(DATA_W'(i), i == 4);
        chk("t1_fc_commit", frame_cnt, 1);
        chk("t1_level", level, 4);
        chk("t1_valid_k", rd_valid, 0);
        cyc();
        chk("t1_valid_k1", rd_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("t1_valid", rd_valid, 1);
            chk("t1_data", rd_data, i);
            chk("t1_last", rd_last, i == 4);
        end
        chk("t1_fc_before_pop", frame_cnt, 1);
        cyc();
        chk("t1_empty", rd_valid, 0);
        chk("t1_fc_end", frame_cnt, 0);
        chk("t1_level_end", level, 0);

        // 2: partial frame dropped, then a clean 2-beat frame
        for (int i = 0; i < 3; i++) beat(16'h0010 + DATA_W'(i), 1'b0);
        chk("t2_level_spec", level, 3);
        wr_drop = 1'b1; cyc(); wr_drop = 1'b0;
        chk("t2_level_drop", level, 0);
        cyc(); cyc();
        chk("t2_no_valid", rd_valid, 0);
        chk("t2_fc", frame_cnt, 0);
        beat(16'h0020, 1'b0);
        beat(16'h0021, 1'b1);
        chk("t2_fc_commit", frame_cnt, 1);
        cyc(); cyc();
        chk("t2_rd0", rd_data, 16'h0020);
        chk("t2_rd0_last", rd_last, 0);
        cyc();
        chk("t2_rd1", rd_data, 16'h0021);
        chk("t2_rd1_last", rd_last, 1);
        cyc();
        chk("t2_empty", rd_valid, 0);
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
        chk("t2_drop_cnt", drop_cnt, 1);
`endif

        // 3: 20-beat frame overflows a 16-deep store
        rd_ready = 1'b0;
        ovf_n = 0;
        for (int i = 0; i < 20; i++) begin
            beat(16'h0100 + DATA_W'(i), i == 19);
            if (wr_ovf) ovf_n++;
            if (i == 15) chk("t3_level_full", level, 16);
            if (i == 19) chk("t3_ovf_beat20", wr_ovf, 1);
        end
        cyc();
        chk("t3_ovf_drop", wr_ovf, 0);
        chk("t3_ovf_count", ovf_n, 1);
        chk("t3_level", level, 0);
        chk("t3_fc", frame_cnt, 0);
        chk("t3_no_valid", rd_valid, 0);
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
        chk("t3_drop_cnt", drop_cnt, 2);
`endif

        // 4: frames A and B, reader toggles ready
        exp_d[0] = 16'h00A0; exp_d[1] = 16'h00A1;
        exp_d[2] = 16'h00B0; exp_d[3] = 16'h00B1; exp_d[4] = 16'h00B2;
        exp_l[0] = 1'b0; exp_l[1] = 1'b1; exp_l[2] = 1'b0; exp_l[3] = 1'b0; exp_l[4] = 1'b1;
        beat(16'h00A0, 1'b0);
        beat(16'h00A1, 1'b1);
        chk("t4_fc_a", frame_cnt, 1);
        beat(16'h00B0, 1'b0);
        beat(16'h00B1, 1'b0);
        beat(16'h00B2, 1'b1);
        chk("t4_fc_peak", frame_cnt, 2);
        chk("t4_level", level, 3);
        chk("t4_head", rd_data, 16'h00A0);
        got = 0;
        for (int t = 0; t < 40 && got < 5; t++) begin
            rr = (t % 2 == 0);
            rd_ready = rr;
            prev = rd_data;
            pv = rd_valid;
            if (rd_valid && rr) begin
                chk("t4_order_data", rd_data, exp_d[got]);
                chk("t4_order_last", rd_last, exp_l[got]);
                got++;
            end
            cyc();
            if (pv && !rr) begin
                chk("t4_hold_valid", rd_valid, 1);
                chk("t4_hold_data", rd_data, prev);
            end
        end
        chk("t4_words_read", got, 5);
        rd_ready = 1'b0;
        cyc();
        chk("t4_fc_end", frame_cnt, 0);
        chk("t4_empty", rd_valid, 0);

        // 5: wr_last and wr_drop together
        rd_ready = 1'b1;
        beat(16'h0050, 1'b0);
        wr_drop = 1'b1;
        beat(16'h0051, 1'b1);
        wr_drop = 1'b0;
        chk("t5_fc", frame_cnt, 0);
        chk("t5_level", level, 0);
        cyc();
        chk("t5_no_ovf", wr_ovf, 0);
        cyc();
        chk("t5_no_valid", rd_valid, 0);
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
        chk("t5_drop_cnt", drop_cnt, 3);
`endif

        // 6: 15 words in 3 frames, reset during the read
        rd_ready = 1'b0;
        for (int i = 0; i < 15; i++) beat(16'h0060 + DATA_W'(i), i % 5 == 4);
        chk("t6_fc", frame_cnt, 3);
        chk("t6_level", level, 13);
        chk("t6_head", rd_data, 16'h0060);
        rd_ready = 1'b1;
        cyc();
        chk("t6_next", rd_data, 16'h0061);
        rst = 1'b1; rd_ready = 1'b0;
        cyc();
        rst = 1'b0;
        chk("t6_rst_valid", rd_valid, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_fc", frame_cnt, 0);
        chk("t6_rst_ovf", wr_ovf, 0);
`ifdef ETH_PKT_FIFO_DROP_CNT_EN
        chk("t6_rst_drop_cnt", drop_cnt, 0);
`endif
        rd_ready = 1'b1;
        beat(16'h0070, 1'b0);
        beat(16'h0071, 1'b1);
        cyc(); cyc();
        chk("t6_post_d0", rd_data, 16'h0070);
        chk("t6_post_v0", rd_valid, 1);
        cyc();
        chk("t6_post_d1", rd_data, 16'h0071);
        chk("t6_post_l1", rd_last, 1);
        cyc();
        chk("t6_post_empty", rd_valid, 0);
        chk("t6_post_fc", frame_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
